// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit alucontrol op codes and the multiplier FSM state encoding.
// Imported by alu_exec_unit, alu_mul_seq and the upstream ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1111;

    typedef enum logic {
        StIdle,
        StMul
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: WIDTH steps, busy while iterating, one-cycle done pulse.
// With ALU_MUL_HI_EN defined the accumulator widens to 2*WIDTH and the upper half drives hi.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod
`ifdef ALU_MUL_HI_EN
    ,
    output logic [WIDTH-1:0] hi
`endif
);

`ifdef ALU_MUL_HI_EN
    localparam int unsigned AW = 2 * WIDTH;
`else
    localparam int unsigned AW = WIDTH;
`endif
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e       state_q;
    logic [AW-1:0]    mcand_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] prod_q;
`ifdef ALU_MUL_HI_EN
    logic [WIDTH-1:0] hi_q;
`endif

    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
`ifdef ALU_MUL_HI_EN
            hi_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= AW'(a);
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StMul;
                    end
                end
                StMul: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Last step: publish the fully accumulated product in the same edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        prod_q  <= acc_next[WIDTH-1:0];
`ifdef ALU_MUL_HI_EN
                        hi_q    <= acc_next[AW-1:WIDTH];
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;
`ifdef ALU_MUL_HI_EN
    assign hi   = hi_q;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative multiplier with busy/done.
// Optional ALU_MUL_HI_EN adds the hi output carrying the upper half of the MUL product.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         alucontrol,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy,
    output logic               done
`ifdef ALU_MUL_HI_EN
    ,
    output logic [WIDTH-1:0]   hi
`endif
);

    logic [WIDTH-1:0] sc_val;
    logic             is_mul;
    logic             issue;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] sc_result_q;
    logic             sc_done_q;
    logic             sel_mul_q;

    // Unknown codes (including X) fall to the default and produce zero.
    always_comb begin
        sc_val = '0;
        is_mul = 1'b0;
        case (alucontrol)
            ALU_ADD:  sc_val = a + b;
            ALU_SUB:  sc_val = a - b;
            ALU_AND:  sc_val = a & b;
            ALU_OR:   sc_val = a | b;
            ALU_NOR:  sc_val = ~(a | b);
            ALU_SLT:  sc_val = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: sc_val = {{(WIDTH - 1){1'b0}}, (a < b)};
            ALU_SLL:  sc_val = b << shamt;
            ALU_SRL:  sc_val = b >> shamt;
            ALU_MUL:  is_mul = 1'b1;
            default:  sc_val = '0;
        endcase
    end

    assign issue     = start & ~mul_busy;
    assign mul_start = issue & is_mul;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
`ifdef ALU_MUL_HI_EN
        ,
        .hi    (hi)
`endif
    );

    // sel_mul_q remembers which path wrote last so result holds between done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sc_result_q <= '0;
            sc_done_q   <= 1'b0;
            sel_mul_q   <= 1'b0;
        end else begin
            sc_done_q <= 1'b0;
            if (mul_done) begin
                sel_mul_q <= 1'b1;
            end
            if (issue && !is_mul) begin
                sc_result_q <= sc_val;
                sc_done_q   <= 1'b1;
                sel_mul_q   <= 1'b0;
            end
        end
    end

    assign result = (mul_done || sel_mul_q) ? mul_prod : sc_result_q;
    assign zero   = (result == '0);
    assign busy   = mul_busy;
    assign done   = sc_done_q | mul_done;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; hi checks compile in with ALU_MUL_HI_EN.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
`ifdef ALU_MUL_HI_EN
    logic [31:0] hi;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int bcnt;
    int dcnt;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
`ifdef ALU_MUL_HI_EN
        ,
        .hi         (hi)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh);
        start      = 1'b1;
        alucontrol = op;
        a          = av;
        b          = bv;
        shamt      = sh;
    endtask

    // Called just after the edge that sampled a MUL start; injects an ADD start at step inj_at.
    task automatic wait_done(input int inj_at, output int l, output int bc);
        l  = 0;
        bc = 0;
        while (!done && l < 40) begin
            if (busy) bc++;
            if (l == inj_at) issue(ALU_ADD, 32'd100, 32'd200, 5'd0);
            else start = 1'b0;
            step();
            l++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        alucontrol = 4'b0000;
        a = '0;
        b = '0;
        shamt = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_result", result, 32'h0);
        chk("reset_zero", {31'b0, zero}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
`ifdef ALU_MUL_HI_EN
        chk("reset_hi", hi, 32'h0);
`endif

        // ADD wraps into the sign bit
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        step();
        start = 1'b0;
        chk("add_result", result, 32'h8000_0000);
        chk("add_zero", {31'b0, zero}, 32'd0);
        chk("add_done", {31'b0, done}, 32'd1);
        chk("add_busy", {31'b0, busy}, 32'd0);
        step();
        chk("add_done_drop", {31'b0, done}, 32'd0);
        chk("add_hold", result, 32'h8000_0000);

        // SUB / SLT / SLTU back-to-back
        issue(ALU_SUB, 32'd5, 32'd5, 5'd0);
        step();
        chk("sub_result", result, 32'h0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        chk("sub_done", {31'b0, done}, 32'd1);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
        step();
        chk("slt_result", result, 32'h1);
        chk("slt_done", {31'b0, done}, 32'd1);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
        step();
        chk("sltu_result", result, 32'h0);
        chk("sltu_done", {31'b0, done}, 32'd1);

        // Logic ops
        issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        step();
        chk("and_result", result, 32'hF000_F000);
        issue(ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        step();
        chk("or_result", result, 32'hFFF0_FFF0);
        issue(ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        step();
        chk("nor_result", result, 32'h000F_000F);

        // Undefined op code clears result
        issue(4'b1010, 32'h1234, 32'h5678, 5'd3);
        step();
        chk("undef_result", result, 32'h0);
        chk("undef_zero", {31'b0, zero}, 32'd1);
        chk("undef_done", {31'b0, done}, 32'd1);

        // Shifts at the boundary amount
        issue(ALU_SLL, 32'h0, 32'h1, 5'd31);
        step();
        chk("sll_result", result, 32'h8000_0000);
        issue(ALU_SRL, 32'h0, 32'h8000_0000, 5'd31);
        step();
        chk("srl_result", result, 32'h1);
        start = 1'b0;
        step();
        chk("srl_hold", result, 32'h1);

        // MUL latency, busy length, result hold while iterating
        issue(ALU_MUL, 32'd12345, 32'd6789, 5'd0);
        step();
        chk("mul_busy_start", {31'b0, busy}, 32'd1);
        chk("mul_hold_old", result, 32'h1);
        chk("mul_no_early_done", {31'b0, done}, 32'd0);
        wait_done(-1, lat, bcnt);
        chk("mul_latency", lat, 32'd32);
        chk("mul_busy_cycles", bcnt, 32'd32);
        chk("mul_result", result, 32'd83810205);
        chk("mul_zero", {31'b0, zero}, 32'd0);
        chk("mul_busy_end", {31'b0, busy}, 32'd0);
        step();
        chk("mul_single_done", {31'b0, done}, 32'd0);
        chk("mul_hold", result, 32'd83810205);

        // start during MUL is ignored and operand changes have no effect
        issue(ALU_MUL, 32'd3, 32'd7, 5'd0);
        step();
        wait_done(4, lat, bcnt);
        chk("ign_latency", lat, 32'd32);
        chk("ign_result", result, 32'd21);
        // Back-to-back: ADD issued in the done cycle launches with no bubble
        issue(ALU_ADD, 32'd1, 32'd1, 5'd0);
        step();
        start = 1'b0;
        chk("b2b_result", result, 32'd2);
        chk("b2b_done", {31'b0, done}, 32'd1);

        // Reset aborts an in-flight MUL
        issue(ALU_MUL, 32'd3, 32'd7, 5'd0);
        step();
        start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_zero", {31'b0, zero}, 32'd1);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) dcnt++;
        end
        chk("abort_quiet", dcnt, 32'd0);

`ifdef ALU_MUL_HI_EN
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        step();
        wait_done(-1, lat, bcnt);
        chk("mulhi_result", result, 32'h1);
        chk("mulhi_hi", hi, 32'hFFFF_FFFE);
        issue(ALU_ADD, 32'd2, 32'd3, 5'd0);
        step();
        start = 1'b0;
        chk("hi_hold_add", hi, 32'hFFFF_FFFE);
        chk("hi_add_result", result, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
